// File: rtl/rob_module_pkg.sv
// rob_module_pkg: shared widths, flag/FU/op types and the reorder-buffer entry layout.
package rob_module_pkg;
  localparam int ROB_IDX_SIZE = 4;
  localparam int GPR_SIZE = 32;
  localparam int GPR_IDX_SIZE = 5;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;
  typedef enum logic [1:0] {FU_ALU, FU_MUL, FU_LSU, FU_BRANCH} fu_t;
  typedef enum logic [3:0] {OP_ADD, OP_SUB, OP_AND, OP_ORR, OP_EOR, OP_LSL, OP_LSR, OP_MOV} alu_op_t;
  typedef struct packed {
    logic valid;
    logic done;
    logic [GPR_IDX_SIZE-1:0] dst;
    logic set_nzcv;
    logic [GPR_SIZE-1:0] value;
    nzcv_t nzcv;
  } rob_entry_t;
  function automatic logic [ROB_IDX_SIZE-1:0] wrap_inc(input logic [ROB_IDX_SIZE-1:0] i, input int depth);
    return (int'(i) == depth - 1) ? '0 : i + 1'b1;
  endfunction
endpackage

// File: rtl/rob_module_if.sv
// rob_module_if: register-file, FU and reservation-station signals of the reorder buffer.
interface rob_module_if;
  import rob_module_pkg::*;
  logic in_reg_done;
  logic in_reg_src1_valid, in_reg_src2_valid, in_reg_nzcv_valid;
  logic [GPR_SIZE-1:0] in_reg_src1_value, in_reg_src2_value;
  logic [ROB_IDX_SIZE-1:0] in_reg_src1_rob_index, in_reg_src2_rob_index, in_reg_nzcv_rob_index;
  nzcv_t in_reg_nzcv;
  logic [GPR_IDX_SIZE-1:0] in_reg_dst;
  logic in_reg_set_nzcv, in_reg_instr_uses_nzcv;
  fu_t in_reg_fu_id;
  alu_op_t in_reg_fu_op;
  logic in_fu_done;
  logic [ROB_IDX_SIZE-1:0] in_fu_rob_index;
  logic [GPR_SIZE-1:0] in_fu_value;
  nzcv_t in_fu_nzcv;
  logic [ROB_IDX_SIZE-1:0] out_reg_next_rob_index;
  logic out_full;
  logic out_reg_should_commit;
  logic [GPR_SIZE-1:0] out_reg_commit_value;
  logic [GPR_IDX_SIZE-1:0] out_reg_reg_index;
  logic [ROB_IDX_SIZE-1:0] out_reg_commit_rob_index;
  logic out_reg_set_nzcv;
  nzcv_t out_reg_nzcv;
  logic out_rs_done;
  fu_t out_rs_fu_id;
  alu_op_t out_rs_fu_op;
  logic [ROB_IDX_SIZE-1:0] out_rs_dst_rob_index;
  logic out_rs_src1_valid, out_rs_src2_valid, out_rs_nzcv_valid;
  logic [GPR_SIZE-1:0] out_rs_src1_value, out_rs_src2_value;
  logic [ROB_IDX_SIZE-1:0] out_rs_src1_rob_index, out_rs_src2_rob_index, out_rs_nzcv_rob_index;
  nzcv_t out_rs_nzcv;
  logic out_rs_instr_uses_nzcv, out_rs_set_nzcv;
  modport master (
    output in_reg_done, in_reg_src1_valid, in_reg_src2_valid, in_reg_nzcv_valid,
    output in_reg_src1_value, in_reg_src2_value, in_reg_src1_rob_index, in_reg_src2_rob_index,
    output in_reg_nzcv_rob_index, in_reg_nzcv, in_reg_dst, in_reg_set_nzcv, in_reg_instr_uses_nzcv,
    output in_reg_fu_id, in_reg_fu_op, in_fu_done, in_fu_rob_index, in_fu_value, in_fu_nzcv,
    input out_reg_next_rob_index, out_full, out_reg_should_commit, out_reg_commit_value,
    input out_reg_reg_index, out_reg_commit_rob_index, out_reg_set_nzcv, out_reg_nzcv,
    input out_rs_done, out_rs_fu_id, out_rs_fu_op, out_rs_dst_rob_index,
    input out_rs_src1_valid, out_rs_src1_value, out_rs_src1_rob_index,
    input out_rs_src2_valid, out_rs_src2_value, out_rs_src2_rob_index,
    input out_rs_nzcv_valid, out_rs_nzcv, out_rs_nzcv_rob_index, out_rs_instr_uses_nzcv, out_rs_set_nzcv
  );
  modport slave (
    input in_reg_done, in_reg_src1_valid, in_reg_src2_valid, in_reg_nzcv_valid,
    input in_reg_src1_value, in_reg_src2_value, in_reg_src1_rob_index, in_reg_src2_rob_index,
    input in_reg_nzcv_rob_index, in_reg_nzcv, in_reg_dst, in_reg_set_nzcv, in_reg_instr_uses_nzcv,
    input in_reg_fu_id, in_reg_fu_op, in_fu_done, in_fu_rob_index, in_fu_value, in_fu_nzcv,
    output out_reg_next_rob_index, out_full, out_reg_should_commit, out_reg_commit_value,
    output out_reg_reg_index, out_reg_commit_rob_index, out_reg_set_nzcv, out_reg_nzcv,
    output out_rs_done, out_rs_fu_id, out_rs_fu_op, out_rs_dst_rob_index,
    output out_rs_src1_valid, out_rs_src1_value, out_rs_src1_rob_index,
    output out_rs_src2_valid, out_rs_src2_value, out_rs_src2_rob_index,
    output out_rs_nzcv_valid, out_rs_nzcv, out_rs_nzcv_rob_index, out_rs_instr_uses_nzcv, out_rs_set_nzcv
  );
endinterface

// File: rtl/rob_operand_resolve.sv
// rob_operand_resolve: picks one operand from the register file, a completed ROB entry,
// or (with ROB_WB_BYPASS_EN) the FU result being written back this cycle.
module rob_operand_resolve
  import rob_module_pkg::*;
#(
  parameter int W = GPR_SIZE,
  parameter int D = 2 ** ROB_IDX_SIZE
) (
  input  logic src_valid,
  input  logic [W-1:0] src_value,
  input  logic [ROB_IDX_SIZE-1:0] src_idx,
  input  logic [D-1:0] ready,
  input  logic [W-1:0] data [D],
`ifdef ROB_WB_BYPASS_EN
  input  logic fu_done,
  input  logic [ROB_IDX_SIZE-1:0] fu_idx,
  input  logic [W-1:0] fu_value,
`endif
  output logic valid,
  output logic [W-1:0] value,
  output logic [ROB_IDX_SIZE-1:0] idx
);
  logic byp;
  logic [W-1:0] byp_value;
`ifdef ROB_WB_BYPASS_EN
  assign byp = fu_done && fu_idx == src_idx;
  assign byp_value = fu_value;
`else
  assign byp = 1'b0;
  assign byp_value = '0;
`endif
  assign valid = src_valid || ready[src_idx] || byp;
  assign value = src_valid ? src_value : ready[src_idx] ? data[src_idx] : byp ? byp_value : '0;
  assign idx = src_idx;
endmodule

// File: rtl/rob_module.sv
// rob_module: reorder buffer allocating, dispatching and committing in program order.
// Optional FU-result bypass into operand resolution: define ROB_WB_BYPASS_EN.
module rob_module
  import rob_module_pkg::*;
#(
  parameter int ROB_DEPTH = 2 ** ROB_IDX_SIZE
) (
  input logic in_clk,
  input logic in_rst_n,
  rob_module_if.slave bus
);
  localparam int CW = ROB_IDX_SIZE + 1;
  rob_entry_t ent [ROB_DEPTH];
  logic [ROB_IDX_SIZE-1:0] head, tail;
  logic [CW-1:0] count;
  logic alloc, commit;
  logic [ROB_DEPTH-1:0] ready;
  logic [GPR_SIZE-1:0] vals [ROB_DEPTH];
  logic [3:0] flags [ROB_DEPTH];
  logic s1_valid, s2_valid, n_valid;
  logic [GPR_SIZE-1:0] s1_value, s2_value;
  logic [3:0] n_value;
  logic [ROB_IDX_SIZE-1:0] s1_idx, s2_idx, n_idx;
  assign bus.out_full = count == CW'(ROB_DEPTH);
  assign bus.out_reg_next_rob_index = tail;
  assign alloc = bus.in_reg_done && !bus.out_full;
  // done is registered, so a writeback to head only becomes committable next cycle
  assign commit = count != '0 && ent[head].done;
  always_comb begin
    for (int i = 0; i < ROB_DEPTH; i++) begin
      ready[i] = ent[i].valid && ent[i].done;
      vals[i] = ent[i].value;
      flags[i] = ent[i].nzcv;
    end
  end
  rob_operand_resolve #(.W(GPR_SIZE), .D(ROB_DEPTH)) u_src1 (
    .src_valid(bus.in_reg_src1_valid), .src_value(bus.in_reg_src1_value),
    .src_idx(bus.in_reg_src1_rob_index), .ready(ready), .data(vals),
`ifdef ROB_WB_BYPASS_EN
    .fu_done(bus.in_fu_done), .fu_idx(bus.in_fu_rob_index), .fu_value(bus.in_fu_value),
`endif
    .valid(s1_valid), .value(s1_value), .idx(s1_idx)
  );
  rob_operand_resolve #(.W(GPR_SIZE), .D(ROB_DEPTH)) u_src2 (
    .src_valid(bus.in_reg_src2_valid), .src_value(bus.in_reg_src2_value),
    .src_idx(bus.in_reg_src2_rob_index), .ready(ready), .data(vals),
`ifdef ROB_WB_BYPASS_EN
    .fu_done(bus.in_fu_done), .fu_idx(bus.in_fu_rob_index), .fu_value(bus.in_fu_value),
`endif
    .valid(s2_valid), .value(s2_value), .idx(s2_idx)
  );
  rob_operand_resolve #(.W(4), .D(ROB_DEPTH)) u_nzcv (
    .src_valid(bus.in_reg_nzcv_valid), .src_value(bus.in_reg_nzcv),
    .src_idx(bus.in_reg_nzcv_rob_index), .ready(ready), .data(flags),
`ifdef ROB_WB_BYPASS_EN
    .fu_done(bus.in_fu_done), .fu_idx(bus.in_fu_rob_index), .fu_value(bus.in_fu_nzcv),
`endif
    .valid(n_valid), .value(n_value), .idx(n_idx)
  );
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) ent[i] <= '0;
      bus.out_reg_should_commit <= 1'b0;
      bus.out_reg_commit_value <= '0;
      bus.out_reg_reg_index <= '0;
      bus.out_reg_commit_rob_index <= '0;
      bus.out_reg_set_nzcv <= 1'b0;
      bus.out_reg_nzcv <= '0;
      bus.out_rs_done <= 1'b0;
      bus.out_rs_fu_id <= FU_ALU;
      bus.out_rs_fu_op <= OP_ADD;
      bus.out_rs_dst_rob_index <= '0;
      bus.out_rs_src1_valid <= 1'b0;
      bus.out_rs_src1_value <= '0;
      bus.out_rs_src1_rob_index <= '0;
      bus.out_rs_src2_valid <= 1'b0;
      bus.out_rs_src2_value <= '0;
      bus.out_rs_src2_rob_index <= '0;
      bus.out_rs_nzcv_valid <= 1'b0;
      bus.out_rs_nzcv <= '0;
      bus.out_rs_nzcv_rob_index <= '0;
      bus.out_rs_instr_uses_nzcv <= 1'b0;
      bus.out_rs_set_nzcv <= 1'b0;
    end else begin
      if (bus.in_fu_done && ent[bus.in_fu_rob_index].valid && !ent[bus.in_fu_rob_index].done) begin
        ent[bus.in_fu_rob_index].done <= 1'b1;
        ent[bus.in_fu_rob_index].value <= bus.in_fu_value;
        ent[bus.in_fu_rob_index].nzcv <= bus.in_fu_nzcv;
      end
      if (alloc) begin
        ent[tail] <= '{valid: 1'b1, done: 1'b0, dst: bus.in_reg_dst, set_nzcv: bus.in_reg_set_nzcv,
                       value: '0, nzcv: '0};
        tail <= wrap_inc(tail, ROB_DEPTH);
      end
      if (commit) begin
        ent[head].valid <= 1'b0;
        head <= wrap_inc(head, ROB_DEPTH);
      end
      count <= count + CW'(alloc) - CW'(commit);
      bus.out_rs_done <= alloc;
      if (alloc) begin
        bus.out_rs_fu_id <= bus.in_reg_fu_id;
        bus.out_rs_fu_op <= bus.in_reg_fu_op;
        bus.out_rs_dst_rob_index <= tail;
        bus.out_rs_src1_valid <= s1_valid;
        bus.out_rs_src1_value <= s1_value;
        bus.out_rs_src1_rob_index <= s1_idx;
        bus.out_rs_src2_valid <= s2_valid;
        bus.out_rs_src2_value <= s2_value;
        bus.out_rs_src2_rob_index <= s2_idx;
        bus.out_rs_nzcv_valid <= n_valid;
        bus.out_rs_nzcv <= nzcv_t'(n_value);
        bus.out_rs_nzcv_rob_index <= n_idx;
        bus.out_rs_instr_uses_nzcv <= bus.in_reg_instr_uses_nzcv;
        bus.out_rs_set_nzcv <= bus.in_reg_set_nzcv;
      end
      bus.out_reg_should_commit <= commit;
      if (commit) begin
        bus.out_reg_commit_value <= ent[head].value;
        bus.out_reg_reg_index <= ent[head].dst;
        bus.out_reg_commit_rob_index <= head;
        bus.out_reg_set_nzcv <= ent[head].set_nzcv;
        bus.out_reg_nzcv <= ent[head].nzcv;
      end
    end
  end
endmodule

// File: tb/tb_rob_module.sv
// tb_rob_module: scoreboard bench for rob_module against a program-order queue model.
module tb_rob_module;
  import rob_module_pkg::*;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  rob_module_if bus();
  rob_module dut (.in_clk(clk), .in_rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [3:0] idx;
    logic [4:0] dst;
    logic set_nzcv;
    logic done;
    logic [31:0] value;
    nzcv_t nzcv;
  } ment_t;
  typedef struct {
    int cyc;
    logic [127:0] v;
  } exp_t;
  ment_t rob_q[$];
  exp_t disp_q[$], com_q[$];
  exp_t me;
  int tail_m = 0, total = 0, bad = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [127:0] disp_vec();
    return {bus.out_rs_fu_id, bus.out_rs_fu_op, bus.out_rs_dst_rob_index,
            bus.out_rs_src1_valid, bus.out_rs_src1_value, bus.out_rs_src1_rob_index,
            bus.out_rs_src2_valid, bus.out_rs_src2_value, bus.out_rs_src2_rob_index,
            bus.out_rs_nzcv_valid, bus.out_rs_nzcv, bus.out_rs_nzcv_rob_index,
            bus.out_rs_instr_uses_nzcv, bus.out_rs_set_nzcv};
  endfunction

  function automatic logic [127:0] com_vec();
    return {bus.out_reg_reg_index, bus.out_reg_commit_value, bus.out_reg_commit_rob_index,
            bus.out_reg_set_nzcv, bus.out_reg_nzcv};
  endfunction

  // operand as the reservation station should see it: {valid, value}
  function automatic logic [32:0] res(input logic rv, input logic [31:0] rval, input logic [3:0] ridx, input bit fl);
    if (rv) return {1'b1, rval};
    foreach (rob_q[i])
      if (rob_q[i].idx == ridx && rob_q[i].done)
        return {1'b1, fl ? 32'(rob_q[i].nzcv) : rob_q[i].value};
`ifdef ROB_WB_BYPASS_EN
    if (bus.in_fu_done && bus.in_fu_rob_index == ridx)
      return {1'b1, fl ? 32'(bus.in_fu_nzcv) : bus.in_fu_value};
`endif
    return 33'b0;
  endfunction

  task automatic step();
    logic [32:0] r1, r2, rn;
    bit full;
    full = rob_q.size() == 16;
    chk("out_full", bus.out_full, full);
    chk("next_rob_index", bus.out_reg_next_rob_index, tail_m);
    r1 = res(bus.in_reg_src1_valid, bus.in_reg_src1_value, bus.in_reg_src1_rob_index, 0);
    r2 = res(bus.in_reg_src2_valid, bus.in_reg_src2_value, bus.in_reg_src2_rob_index, 0);
    rn = res(bus.in_reg_nzcv_valid, 32'(bus.in_reg_nzcv), bus.in_reg_nzcv_rob_index, 1);
    if (rob_q.size() > 0 && rob_q[0].done) begin
      com_q.push_back('{cyc + 1, 128'({rob_q[0].dst, rob_q[0].value, rob_q[0].idx, rob_q[0].set_nzcv, rob_q[0].nzcv})});
      void'(rob_q.pop_front());
    end
    if (bus.in_fu_done)
      foreach (rob_q[i])
        if (rob_q[i].idx == bus.in_fu_rob_index && !rob_q[i].done) begin
          rob_q[i].done = 1;
          rob_q[i].value = bus.in_fu_value;
          rob_q[i].nzcv = bus.in_fu_nzcv;
        end
    if (bus.in_reg_done && !full) begin
      disp_q.push_back('{cyc + 1, 128'({bus.in_reg_fu_id, bus.in_reg_fu_op, 4'(tail_m),
        r1[32], r1[31:0], bus.in_reg_src1_rob_index, r2[32], r2[31:0], bus.in_reg_src2_rob_index,
        rn[32], rn[3:0], bus.in_reg_nzcv_rob_index, bus.in_reg_instr_uses_nzcv, bus.in_reg_set_nzcv})});
      rob_q.push_back('{4'(tail_m), bus.in_reg_dst, bus.in_reg_set_nzcv, 1'b0, 32'd0, nzcv_t'(4'd0)});
      tail_m = (tail_m + 1) % 16;
    end
    @(negedge clk);
    #1;
    bus.in_reg_done = 0;
    bus.in_fu_done = 0;
  endtask

  task automatic issue(input logic [4:0] dst, input logic v1, input logic [31:0] s1, input logic [3:0] i1,
                       input logic v2, input logic [31:0] s2, input logic [3:0] i2);
    bus.in_reg_done = 1;
    bus.in_reg_dst = dst;
    bus.in_reg_src1_valid = v1;
    bus.in_reg_src1_value = s1;
    bus.in_reg_src1_rob_index = i1;
    bus.in_reg_src2_valid = v2;
    bus.in_reg_src2_value = s2;
    bus.in_reg_src2_rob_index = i2;
    bus.in_reg_nzcv_valid = 1;
    bus.in_reg_nzcv = nzcv_t'(4'ha);
    bus.in_reg_nzcv_rob_index = 0;
    bus.in_reg_set_nzcv = dst[0];
    bus.in_reg_instr_uses_nzcv = dst[1];
    bus.in_reg_fu_id = FU_ALU;
    bus.in_reg_fu_op = OP_ADD;
  endtask

  task automatic fu(input logic [3:0] idx, input logic [31:0] val);
    bus.in_fu_done = 1;
    bus.in_fu_rob_index = idx;
    bus.in_fu_value = val;
    bus.in_fu_nzcv = nzcv_t'(val[3:0]);
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && rob_q.size() > 0; k++) begin
      foreach (rob_q[i])
        if (!rob_q[i].done && !bus.in_fu_done) fu(rob_q[i].idx, $urandom);
      step();
    end
    repeat (3) step();
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.out_rs_done) begin
          if (disp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL dispatch: unexpected pulse at cycle %0d, none required", cyc);
          end else begin
            me = disp_q.pop_front();
            chk("dispatch cycle", cyc, me.cyc);
            chk("dispatch fields", disp_vec(), me.v);
          end
        end
        if (bus.out_reg_should_commit) begin
          if (com_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL commit: unexpected pulse at cycle %0d, none required", cyc);
          end else begin
            me = com_q.pop_front();
            chk("commit cycle", cyc, me.cyc);
            chk("commit fields", com_vec(), me.v);
          end
        end
      end
    end
  end

  initial begin
    bus.in_reg_done = 0;
    bus.in_fu_done = 0;
    issue(0, 0, 0, 0, 0, 0, 0);
    bus.in_reg_done = 0;
    fu(0, 0);
    bus.in_fu_done = 0;
    repeat (2) @(negedge clk);
    chk("reset rs outputs", disp_vec(), 0);
    chk("reset other outputs", {bus.out_reg_should_commit, bus.out_rs_done, bus.out_full,
                                bus.out_reg_next_rob_index, com_vec()}, 0);
    rst_n = 1;
    #1;
    // single instruction: dispatch next cycle, commit one cycle after writeback
    issue(3, 1, 7, 0, 1, 9, 0);
    step();
    step();
    step();
    fu(0, 16);
    step();
    repeat (2) step();
    // dependency: entry 2 done with 0x55 resolves a later src1
    issue(5, 1, 1, 0, 1, 2, 0);
    step();
    issue(6, 1, 3, 0, 1, 4, 0);
    step();
    fu(2, 32'h55);
    step();
    issue(7, 0, 0, 2, 1, 3, 0);
    step();
    fu(1, 32'h11);
    step();
    fu(3, 32'h33);
    step();
    repeat (3) step();
    // in-order commit with reversed completion
    for (int i = 0; i < 3; i++) begin
      issue(5'(8 + i), 1, i, 0, 1, i, 0);
      step();
    end
    fu(6, 32'h66);
    step();
    step();
    fu(5, 32'h65);
    step();
    step();
    fu(4, 32'h64);
    step();
    repeat (4) step();
    // same-cycle writeback and reference of the same entry
    issue(9, 1, 0, 0, 1, 0, 0);
    step();
    issue(10, 1, 5, 0, 0, 0, 7);
    fu(7, 32'h1234);
    step();
    drain();
    // fill, drop one when full, then wrap
    for (int i = 0; i < 16; i++) begin
      issue(5'(i), 1, i, 0, 1, i, 0);
      step();
    end
    issue(31, 1, 1, 0, 1, 1, 0);
    step();
    fu(rob_q[0].idx, 32'hf00d);
    step();
    issue(30, 1, 2, 0, 1, 2, 0);
    step();
    issue(29, 1, 2, 0, 1, 2, 0);
    step();
    drain();
    // asynchronous reset with five entries in flight
    for (int i = 0; i < 5; i++) begin
      issue(5'(i + 1), 1, i, 0, 1, i, 0);
      step();
    end
    #1 rst_n = 0;
    #1;
    chk("mid reset rs outputs", disp_vec(), 0);
    chk("mid reset other outputs", {bus.out_reg_should_commit, bus.out_rs_done, bus.out_full,
                                    bus.out_reg_next_rob_index, com_vec()}, 0);
    rob_q.delete();
    disp_q.delete();
    com_q.delete();
    tail_m = 0;
    rst_n = 1;
    issue(12, 1, 3, 0, 1, 4, 0);
    step();
    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      issue(5'($urandom), 1'($urandom), $urandom, 4'($urandom), 1'($urandom), $urandom, 4'($urandom));
      bus.in_reg_done = $urandom_range(0, 2) != 0;
      bus.in_reg_nzcv_valid = 1'($urandom);
      bus.in_reg_nzcv = nzcv_t'(4'($urandom));
      bus.in_reg_nzcv_rob_index = 4'($urandom);
      bus.in_reg_fu_id = fu_t'(2'($urandom));
      bus.in_reg_fu_op = alu_op_t'(4'($urandom_range(0, 7)));
      if (rob_q.size() > 0 && $urandom_range(0, 1) == 1) begin
        if (!bus.in_reg_src1_valid) bus.in_reg_src1_rob_index = rob_q[$urandom_range(0, rob_q.size() - 1)].idx;
        if (!bus.in_reg_nzcv_valid) bus.in_reg_nzcv_rob_index = rob_q[$urandom_range(0, rob_q.size() - 1)].idx;
      end
      if ($urandom_range(0, 1) == 1)
        fu((rob_q.size() > 0 && $urandom_range(0, 7) != 0) ? rob_q[$urandom_range(0, rob_q.size() - 1)].idx
                                                            : 4'($urandom), $urandom);
      step();
    end
    drain();
    chk("pending dispatches", disp_q.size(), 0);
    chk("pending commits", com_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
